// File: rtl/change_dispense_ctrl_if.sv
// Bundle of change-dispense request, hopper handshake and inventory signals.
// The slave modport is the controller; the master modport is the machine/hopper side.
interface change_dispense_ctrl_if #(
    parameter int CNT_W = 8
);
    logic             start;
    logic [7:0]       change_amt;
    logic             inv_load;
    logic [CNT_W-1:0] inv5_in;
    logic [CNT_W-1:0] inv10_in;
    logic [CNT_W-1:0] inv50_in;
    logic             coin_ack;

    logic             coin_req;
    logic [1:0]       coin_sel;
    logic             busy;
    logic             done;
    logic             shortfall;
    logic [7:0]       remaining;
    logic [CNT_W-1:0] inv5;
    logic [CNT_W-1:0] inv10;
    logic [CNT_W-1:0] inv50;

    modport master (
        output start, change_amt, inv_load, inv5_in, inv10_in, inv50_in, coin_ack,
        input  coin_req, coin_sel, busy, done, shortfall, remaining, inv5, inv10, inv50
    );

    modport slave (
        input  start, change_amt, inv_load, inv5_in, inv10_in, inv50_in, coin_ack,
        output coin_req, coin_sel, busy, done, shortfall, remaining, inv5, inv10, inv50
    );
endinterface

// File: rtl/change_dispense_ctrl.sv
// Returns change one coin at a time, largest available denomination first,
// tracking hopper inventory and pacing coins with a fixed gap.
module change_dispense_ctrl #(
    parameter int TICK_CYCLES = 100000000,
    parameter int CNT_W       = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    change_dispense_ctrl_if.slave bus
);
    localparam int GAP_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

    localparam logic [1:0] SEL_NONE = 2'b00;
    localparam logic [1:0] SEL_5    = 2'b01;
    localparam logic [1:0] SEL_10   = 2'b10;
    localparam logic [1:0] SEL_50   = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        PICK,
        REQ,
        GAP,
        DONE
    } state_t;

    state_t           state;
    logic [GAP_W-1:0] gap_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            gap_cnt       <= '0;
            bus.coin_req  <= 1'b0;
            bus.coin_sel  <= SEL_NONE;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.shortfall <= 1'b0;
            bus.remaining <= '0;
            bus.inv5      <= '0;
            bus.inv10     <= '0;
            bus.inv50     <= '0;
        end else begin
            bus.done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.inv_load) begin
                        bus.inv5  <= bus.inv5_in;
                        bus.inv10 <= bus.inv10_in;
                        bus.inv50 <= bus.inv50_in;
                    end
                    if (bus.start) begin
                        bus.shortfall <= 1'b0;
                        if (bus.change_amt != 8'd0) begin
                            bus.remaining <= bus.change_amt;
                            bus.busy      <= 1'b1;
                            state         <= PICK;
                        end else begin
                            state <= DONE;
                        end
                    end
                end
                PICK: begin
                    // Largest denomination that fits and is in stock wins.
                    if (bus.remaining >= 8'd50 && bus.inv50 != '0) begin
                        bus.coin_sel <= SEL_50;
                        bus.coin_req <= 1'b1;
                        state        <= REQ;
                    end else if (bus.remaining >= 8'd10 && bus.inv10 != '0) begin
                        bus.coin_sel <= SEL_10;
                        bus.coin_req <= 1'b1;
                        state        <= REQ;
                    end else if (bus.remaining >= 8'd5 && bus.inv5 != '0) begin
                        bus.coin_sel <= SEL_5;
                        bus.coin_req <= 1'b1;
                        state        <= REQ;
                    end else begin
                        bus.shortfall <= (bus.remaining != 8'd0);
                        state         <= DONE;
                    end
                end
                REQ: begin
                    if (bus.coin_ack) begin
                        unique case (bus.coin_sel)
                            SEL_50: begin
                                bus.remaining <= bus.remaining - 8'd50;
                                bus.inv50     <= bus.inv50 - CNT_W'(1);
                            end
                            SEL_10: begin
                                bus.remaining <= bus.remaining - 8'd10;
                                bus.inv10     <= bus.inv10 - CNT_W'(1);
                            end
                            SEL_5: begin
                                bus.remaining <= bus.remaining - 8'd5;
                                bus.inv5      <= bus.inv5 - CNT_W'(1);
                            end
                            default: ;
                        endcase
                        bus.coin_req <= 1'b0;
                        bus.coin_sel <= SEL_NONE;
                        gap_cnt      <= GAP_W'(TICK_CYCLES - 1);
                        state        <= GAP;
                    end
                end
                GAP: begin
                    // Counter was preloaded with TICK_CYCLES-1, so GAP spans TICK_CYCLES cycles.
                    if (gap_cnt == '0) begin
                        state <= PICK;
                    end else begin
                        gap_cnt <= gap_cnt - GAP_W'(1);
                    end
                end
                DONE: begin
                    bus.done <= 1'b1;
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_change_dispense_ctrl.sv
// Directed bench for change_dispense_ctrl with a short coin gap.
module tb_change_dispense_ctrl;
    localparam int TICK  = 4;
    localparam int CNT_W = 8;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    change_dispense_ctrl_if #(.CNT_W(CNT_W)) bus ();

    change_dispense_ctrl #(
        .TICK_CYCLES(TICK),
        .CNT_W      (CNT_W)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic apply_stimulus(input logic load, input logic [7:0] i50, input logic [7:0] i10,
                                  input logic [7:0] i5, input logic go, input logic [7:0] amt);
        bus.inv_load   = load;
        bus.inv50_in   = i50;
        bus.inv10_in   = i10;
        bus.inv5_in    = i5;
        bus.start      = go;
        bus.change_amt = amt;
        tick();
        bus.inv_load = 1'b0;
        bus.start    = 1'b0;
    endtask

    // Wait for a coin request, check its code, ack it one cycle later, check the new remaining.
    task automatic expect_coin(input string tag, input logic [1:0] sel, input logic [7:0] rem_after);
        int waited = 0;
        while (!bus.coin_req && waited < 40) begin
            tick();
            waited++;
        end
        check_output({tag, "_req"}, {31'd0, bus.coin_req}, 32'd1);
        check_output({tag, "_sel"}, {30'd0, bus.coin_sel}, {30'd0, sel});
        tick();
        bus.coin_ack = 1'b1;
        tick();
        bus.coin_ack = 1'b0;
        check_output({tag, "_req_drop"}, {31'd0, bus.coin_req}, 32'd0);
        check_output({tag, "_rem"}, {24'd0, bus.remaining}, {24'd0, rem_after});
    endtask

    // Wait for the done pulse with no further coin request, then confirm it lasts one cycle.
    task automatic expect_done(input string tag);
        int waited    = 0;
        int extra_req = 0;
        while (!bus.done && waited < 40) begin
            if (bus.coin_req) extra_req++;
            tick();
            waited++;
        end
        check_output({tag, "_done"}, {31'd0, bus.done}, 32'd1);
        check_output({tag, "_extra_req"}, extra_req, 32'd0);
        tick();
        check_output({tag, "_done_once"}, {31'd0, bus.done}, 32'd0);
        check_output({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
    endtask

    // Pulse reset for one edge and confirm everything is cleared and nothing completes.
    task automatic reset_check(input string tag);
        int stray = 0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_output({tag, "_req"}, {31'd0, bus.coin_req}, 32'd0);
        check_output({tag, "_sel"}, {30'd0, bus.coin_sel}, 32'd0);
        check_output({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
        check_output({tag, "_rem"}, {24'd0, bus.remaining}, 32'd0);
        check_output({tag, "_inv"}, {8'd0, bus.inv50, bus.inv10, bus.inv5}, 32'd0);
        for (int i = 0; i < 10; i++) begin
            if (bus.done || bus.coin_req) stray++;
            tick();
        end
        check_output({tag, "_quiet"}, stray, 32'd0);
    endtask

    initial begin
        int gap_len;
        int unstable;
        checks         = 0;
        errors         = 0;
        rst_n          = 1'b0;
        bus.start      = 1'b0;
        bus.change_amt = '0;
        bus.inv_load   = 1'b0;
        bus.inv5_in    = '0;
        bus.inv10_in   = '0;
        bus.inv50_in   = '0;
        bus.coin_ack   = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;

        $display("[TB] reset state");
        check_output("rst_req", {31'd0, bus.coin_req}, 32'd0);
        check_output("rst_sel", {30'd0, bus.coin_sel}, 32'd0);
        check_output("rst_busy", {31'd0, bus.busy}, 32'd0);
        check_output("rst_done", {31'd0, bus.done}, 32'd0);
        check_output("rst_short", {31'd0, bus.shortfall}, 32'd0);
        check_output("rst_rem", {24'd0, bus.remaining}, 32'd0);
        check_output("rst_inv", {8'd0, bus.inv50, bus.inv10, bus.inv5}, 32'd0);

        $display("[TB] 65 with 2/2/2");
        apply_stimulus(1'b1, 8'd2, 8'd2, 8'd2, 1'b0, 8'd0);
        check_output("t1_load", {8'd0, bus.inv50, bus.inv10, bus.inv5}, 32'h020202);
        apply_stimulus(1'b0, 8'd0, 8'd0, 8'd0, 1'b1, 8'd65);
        check_output("t1_busy", {31'd0, bus.busy}, 32'd1);
        check_output("t1_rem0", {24'd0, bus.remaining}, 32'd65);
        expect_coin("t1_c50", 2'b11, 8'd15);
        expect_coin("t1_c10", 2'b10, 8'd5);
        expect_coin("t1_c5", 2'b01, 8'd0);
        expect_done("t1");
        check_output("t1_short", {31'd0, bus.shortfall}, 32'd0);
        check_output("t1_inv", {8'd0, bus.inv50, bus.inv10, bus.inv5}, 32'h010101);

        $display("[TB] 35 with 0/3/5");
        apply_stimulus(1'b1, 8'd0, 8'd3, 8'd5, 1'b1, 8'd35);
        expect_coin("t2_a", 2'b10, 8'd25);
        expect_coin("t2_b", 2'b10, 8'd15);
        expect_coin("t2_c", 2'b10, 8'd5);
        expect_coin("t2_d", 2'b01, 8'd0);
        expect_done("t2");
        check_output("t2_short", {31'd0, bus.shortfall}, 32'd0);
        check_output("t2_inv", {8'd0, bus.inv50, bus.inv10, bus.inv5}, 32'h000004);

        $display("[TB] 20 with 0/0/1");
        apply_stimulus(1'b1, 8'd0, 8'd0, 8'd1, 1'b1, 8'd20);
        expect_coin("t3_a", 2'b01, 8'd15);
        expect_done("t3a");
        check_output("t3a_short", {31'd0, bus.shortfall}, 32'd1);
        check_output("t3a_rem", {24'd0, bus.remaining}, 32'd15);
        check_output("t3a_inv5", {24'd0, bus.inv5}, 32'd0);

        $display("[TB] 7 with ample stock");
        apply_stimulus(1'b1, 8'd2, 8'd2, 8'd2, 1'b1, 8'd7);
        check_output("t3b_short_clr", {31'd0, bus.shortfall}, 32'd0);
        expect_coin("t3_b", 2'b01, 8'd2);
        expect_done("t3b");
        check_output("t3b_short", {31'd0, bus.shortfall}, 32'd1);
        check_output("t3b_rem", {24'd0, bus.remaining}, 32'd2);

        $display("[TB] zero amount");
        apply_stimulus(1'b0, 8'd0, 8'd0, 8'd0, 1'b1, 8'd0);
        check_output("t4_done_early", {31'd0, bus.done}, 32'd0);
        check_output("t4_busy0", {31'd0, bus.busy}, 32'd0);
        tick();
        check_output("t4_done", {31'd0, bus.done}, 32'd1);
        check_output("t4_busy1", {31'd0, bus.busy}, 32'd0);
        check_output("t4_short", {31'd0, bus.shortfall}, 32'd0);
        tick();
        check_output("t4_done_once", {31'd0, bus.done}, 32'd0);
        check_output("t4_req", {31'd0, bus.coin_req}, 32'd0);

        $display("[TB] stalled ack and gap length");
        apply_stimulus(1'b1, 8'd2, 8'd2, 8'd2, 1'b1, 8'd60);
        tick();
        check_output("t5_req", {31'd0, bus.coin_req}, 32'd1);
        unstable = 0;
        for (int i = 0; i < 10; i++) begin
            apply_stimulus(i[0], 8'd9, 8'd9, 8'd9, ~i[0], 8'd30);
            if (bus.coin_req !== 1'b1 || bus.coin_sel !== 2'b11) unstable++;
        end
        check_output("t5_stable", unstable, 32'd0);
        check_output("t5_rem_hold", {24'd0, bus.remaining}, 32'd60);
        check_output("t5_inv_hold", {8'd0, bus.inv50, bus.inv10, bus.inv5}, 32'h020202);
        bus.coin_ack = 1'b1;
        tick();
        bus.coin_ack = 1'b0;
        check_output("t5_rem_ack", {24'd0, bus.remaining}, 32'd10);
        gap_len = 0;
        while (!bus.coin_req && gap_len < 40) begin
            tick();
            gap_len++;
        end
        check_output("t5_gap", gap_len, TICK + 1);
        expect_coin("t5_b", 2'b10, 8'd0);
        expect_done("t5");
        check_output("t5_short", {31'd0, bus.shortfall}, 32'd0);

        $display("[TB] reset during REQ");
        apply_stimulus(1'b1, 8'd2, 8'd2, 8'd2, 1'b1, 8'd65);
        tick();
        check_output("t6_req_up", {31'd0, bus.coin_req}, 32'd1);
        reset_check("t6_req");

        $display("[TB] reset during GAP");
        apply_stimulus(1'b1, 8'd2, 8'd2, 8'd2, 1'b1, 8'd65);
        expect_coin("t6_c", 2'b11, 8'd15);
        reset_check("t6_gap");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/change_dispense_ctrl.md
Name: change_dispense_ctrl

Overview:
Sequences return of change from the vending machine's money register to the coin hopper. On a start request it latches the change amount and issues one hopper request per coin, using the largest available coin first (50, then 10, then 5). It tracks per-denomination hopper inventory and enforces a pacing gap between coins. It reports completion, the remaining amount, and any shortfall when the inventory cannot cover the full amount.

Parameters:
TICK_CYCLES, 100000000, gap length in clk cycles after each acknowledged coin (minimum 1)
CNT_W, 8, width of each inventory counter

Ports:
clk  in  1  system clock
rst_n  in  1  reset, synchronous, active-low
start  in  1  single-cycle request to dispense change_amt
change_amt  in  8  change to return, NT
inv_load  in  1  load the inventory counters from inv*_in
inv5_in  in  CNT_W  NT5 coin count to load
inv10_in  in  CNT_W  NT10 coin count to load
inv50_in  in  CNT_W  NT50 coin count to load
coin_ack  in  1  hopper has taken the current coin
coin_req  out  1  request hopper to eject one coin
coin_sel  out  2  coin to eject: 01=NT5, 10=NT10, 11=NT50, 00 when idle
busy  out  1  dispense sequence in progress
done  out  1  single-cycle pulse at end of a sequence
shortfall  out  1  previous sequence ended with remaining != 0
remaining  out  8  amount not yet dispensed
inv5, inv10, inv50  out  CNT_W each  current inventory counts

Behaviour:
- All outputs are registered.
- Reset values: coin_req=0, coin_sel=00, busy=0, done=0, shortfall=0, remaining=0, inv*=0, state=IDLE, gap counter=0. Reset in any state aborts the sequence immediately. No coin is counted for a request that was pending when reset asserted.
- States: IDLE, PICK, REQ, GAP, DONE.
- IDLE:
  - inv_load=1 copies inv*_in into inv* on the next edge.
  - inv_load is ignored in all other states.
  - start=1 with change_amt!=0: remaining<=change_amt, shortfall<=0, busy<=1, go to PICK.
  - start=1 with change_amt==0: go to DONE with shortfall<=0 and busy staying 0.
  - If start and inv_load are both high, both take effect; PICK then sees the loaded counts.
- PICK (1 cycle): select the coin, first match wins:
  - remaining>=50 and inv50>0 → NT50
  - remaining>=10 and inv10>0 → NT10
  - remaining>=5 and inv5>0 → NT5
  - On a match: coin_sel<=code, coin_req<=1, go to REQ.
  - No match: go to DONE, with shortfall<=(remaining!=0). Amounts that are not a multiple of 5 therefore always end in shortfall with remaining%5 left over.
- REQ:
  - Hold coin_req=1 and coin_sel stable until coin_ack is sampled high. There is no timeout.
  - On ack: coin_req<=0, coin_sel<=00, remaining<=remaining minus the coin value, the selected inv decrements by 1, gap counter<=TICK_CYCLES-1, go to GAP.
- GAP:
  - The counter decrements each cycle. When the counter==0, go to PICK, so GAP lasts exactly TICK_CYCLES cycles.
  - coin_ack is ignored here.
- DONE: done=1 for exactly one cycle, busy<=0, go to IDLE. shortfall and remaining hold until the next accepted start.
- Latency: start at edge k → PICK after k → coin_req=1 after k+1. Ack sampled at edge m → next coin_req=1 after edge m+TICK_CYCLES+1.
- start while busy or in DONE is ignored. coin_ack while coin_req=0 is ignored.
- Arithmetic: the subtraction never underflows because a coin is only selected when remaining >= its value. Inventory never decrements below 0.

Test Plan:
1. TICK_CYCLES=4, load inv 2/2/2, start change_amt=65, ack each request 1 cycle after it rises → coin_sel sequence 11,10,01; remaining 65→15→5→0; one done pulse; shortfall=0; inv50=inv10=inv5=1.
2. Load inv50=0, inv10=3, inv5=5, start 35 → 10,10,10,01; inv10=0, inv5=4; shortfall=0.
3. Load inv50=0, inv10=0, inv5=1, start 20 → single 01 coin; done; shortfall=1; remaining=15. Separately, start 7 with ample inventory → one NT5, shortfall=1, remaining=2.
4. Start change_amt=0 → done high exactly one cycle, 2 edges after start; coin_req never rises; busy stays 0.
5. Hold coin_ack low for 10 cycles in REQ while pulsing start and inv_load → coin_req stays 1, coin_sel stable, remaining/inv unchanged; gap measured as exactly TICK_CYCLES cycles after ack.
6. rst_n=0 for one edge during REQ and again during GAP → next cycle coin_req=0, coin_sel=00, busy=0, remaining=0, inv*=0, and no done pulse.
